// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - program memory read bus between fetch stage and memory
// Purpose: bundles the program-memory req/ack read handshake.
// Signals:
//   mem_addr  ADDR_W   program memory address (fetch -> memory)
//   mem_req   1        read request, held until ack or timeout (fetch -> memory)
//   mem_ack   1        read done, mem_data valid this cycle (memory -> fetch)
//   mem_data  INSTR_W  instruction word (memory -> fetch)
// Modports: master = fetch stage, slave = program memory.
interface instr_fetch_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9
);
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_req;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_data;

   modport master (
      output mem_addr,
      output mem_req,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_addr,
      input  mem_req,
      output mem_ack,
      output mem_data
   );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage feeding the control unit
// Purpose: fetches the instruction at the address given by control, holds it
//   in an instruction register and presents it on ms_m until control consumes
//   it. A memory that never answers is cut off after TIMEOUT request cycles and
//   a NOP is substituted so the core keeps running.
// Ports:
//   Clk                      in   clock, all state on rising edge
//   Rst                      in   synchronous reset, active-low
//   Address_Instruction_Bus  in   next program address from control
//   consume                  in   control executed the current ms_m
//   mem                      if   program memory read bus (master side)
//   ms_m                     out  instruction to control, NOP_WORD when not valid
//   ir_valid                 out  ms_m holds a fetched or substituted instruction
//   stall                    out  inverse of ir_valid
//   fetch_err                out  sticky: a fetch timed out since reset
//   fetch_count              out  completed fetches, wraps at 256
module instr_fetch #(
   parameter int                 ADDR_W   = 8,
   parameter int                 INSTR_W  = 9,
   parameter logic [INSTR_W-1:0] NOP_WORD = '0,
   parameter int                 TIMEOUT  = 15
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic [ADDR_W-1:0]   Address_Instruction_Bus,
   input  logic                consume,
   instr_fetch_if.master       mem,
   output logic [INSTR_W-1:0]  ms_m,
   output logic                ir_valid,
   output logic                stall,
   output logic                fetch_err,
   output logic [7:0]          fetch_count
);

   typedef enum logic [1:0] {
      S_ADDR = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2
   } state_t;

   // Value of the timer on the last request cycle before giving up.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t             state;
   logic [7:0]         timer;
   logic [INSTR_W-1:0] ir_q;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state        <= S_ADDR;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         ir_q         <= NOP_WORD;
         ir_valid     <= 1'b0;
         fetch_err    <= 1'b0;
         fetch_count  <= 8'd0;
         timer        <= 8'd0;
      end else begin
         case (state)
            S_ADDR: begin
               // The PC written by control on the consume edge is visible here.
               mem.mem_addr <= Address_Instruction_Bus;
               mem.mem_req  <= 1'b1;
               timer        <= 8'd0;
               state        <= S_REQ;
            end
            S_REQ: begin
               // An ack on the final timer cycle still counts as a good fetch.
               if (mem.mem_ack) begin
                  ir_q        <= mem.mem_data;
                  ir_valid    <= 1'b1;
                  mem.mem_req <= 1'b0;
                  fetch_count <= fetch_count + 8'd1;
                  state       <= S_EXEC;
               end else if (timer == TIMER_LAST) begin
                  ir_q        <= NOP_WORD;
                  ir_valid    <= 1'b1;
                  mem.mem_req <= 1'b0;
                  fetch_err   <= 1'b1;
                  fetch_count <= fetch_count + 8'd1;
                  state       <= S_EXEC;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_EXEC: begin
               if (consume) begin
                  ir_valid <= 1'b0;
                  state    <= S_ADDR;
               end
            end
            default: begin
               mem.mem_req <= 1'b0;
               ir_valid    <= 1'b0;
               state       <= S_ADDR;
            end
         endcase
      end
   end

   // Both sources are registers, so ms_m cannot glitch.
   assign ms_m  = ir_valid ? ir_q : NOP_WORD;
   assign stall = ~ir_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
   localparam int         TIMEOUT = 15;
   localparam logic [8:0] NOP     = 9'h000;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [7:0] addr_bus = 8'h00;
   logic       consume = 1'b0;
   logic [8:0] ms_m;
   logic       ir_valid;
   logic       stall;
   logic       fetch_err;
   logic [7:0] fetch_count;

   instr_fetch_if #(.ADDR_W(8), .INSTR_W(9)) mem_if ();

   instr_fetch #(
      .ADDR_W(8), .INSTR_W(9), .NOP_WORD(9'h000), .TIMEOUT(TIMEOUT)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .Address_Instruction_Bus(addr_bus),
      .consume(consume),
      .mem(mem_if.master),
      .ms_m(ms_m),
      .ir_valid(ir_valid),
      .stall(stall),
      .fetch_err(fetch_err),
      .fetch_count(fetch_count)
   );

   always #5 Clk = ~Clk;

   int         checks = 0;
   int         failures = 0;
   logic [8:0] mem_m [256];
   bit         err_m;
   logic [7:0] cnt_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Starts with the DUT in ADDR. delay = number of request cycles without ack
   // before the ack cycle; negative means the memory never answers.
   task automatic fetch(input logic [7:0] addr, input int delay);
      int         n;
      int         exp_req;
      bit         tmo;
      logic [8:0] exp_word;
      tmo      = (delay < 0) || (delay >= TIMEOUT);
      exp_req  = tmo ? TIMEOUT : delay + 1;
      exp_word = tmo ? NOP : mem_m[addr];
      addr_bus = addr;
      tick();
      addr_bus = 8'($urandom);
      n = 0;
      while (mem_if.mem_req === 1'b1 && n < TIMEOUT + 4) begin
         check("req_addr", mem_if.mem_addr, addr);
         check("req_stall", stall, 1);
         mem_if.mem_ack  = (n == delay);
         mem_if.mem_data = (n == delay) ? mem_m[mem_if.mem_addr] : 9'($urandom);
         consume         = 1'($urandom);
         tick();
         n++;
      end
      mem_if.mem_ack = 1'b0;
      consume        = 1'b0;
      if (tmo) err_m = 1'b1;
      cnt_m = cnt_m + 8'd1;
      check("req_cycles", n, exp_req);
      check("ms_m", ms_m, exp_word);
      check("ir_valid", ir_valid, 1);
      check("stall", stall, 0);
      check("fetch_err", fetch_err, err_m);
      check("fetch_count", fetch_count, cnt_m);
      repeat ($urandom_range(0, 3)) begin
         mem_if.mem_ack  = 1'($urandom);
         mem_if.mem_data = 9'($urandom);
         tick();
         check("hold_ms_m", ms_m, exp_word);
         check("hold_req", mem_if.mem_req, 0);
      end
      mem_if.mem_ack = 1'b0;
      consume = 1'b1;
      tick();
      consume = 1'b0;
      check("consumed_valid", ir_valid, 0);
      check("consumed_ms_m", ms_m, NOP);
      check("consumed_req", mem_if.mem_req, 0);
   endtask

   initial begin
      int d;
      int r;
      for (int i = 0; i < 256; i++) mem_m[i] = 9'($urandom);
      mem_if.mem_ack  = 1'b0;
      mem_if.mem_data = 9'h000;

      // Reset held for three cycles.
      Rst = 1'b0;
      repeat (3) tick();
      check("rst_req", mem_if.mem_req, 0);
      check("rst_valid", ir_valid, 0);
      check("rst_stall", stall, 1);
      check("rst_ms_m", ms_m, 9'h000);
      check("rst_err", fetch_err, 0);
      check("rst_count", fetch_count, 0);
      err_m = 1'b0;
      cnt_m = 8'd0;
      Rst = 1'b1;

      // Directed: basic, wait states, ack on last cycle, timeout, address wrap.
      mem_m[8'h10] = 9'h1A5;
      fetch(8'h10, 0);
      fetch(8'h20, 4);
      fetch(8'h30, TIMEOUT - 1);
      fetch(8'h40, -1);
      fetch(8'hFE, 0);
      fetch(8'hFF, 1);
      fetch(8'h00, 0);
      fetch(8'h00, 2);

      // 256 randomized fetches from reset bring the counter back to 0.
      Rst = 1'b0;
      tick();
      Rst = 1'b1;
      err_m = 1'b0;
      cnt_m = 8'd0;
      for (int k = 0; k < 256; k++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5)      d = int'($urandom_range(0, 3));
         else if (r == 6) d = TIMEOUT - 1;
         else if (r == 7) d = TIMEOUT;
         else if (r == 8) d = -1;
         else             d = int'($urandom_range(4, 13));
         fetch(8'($urandom), d);
      end
      check("wrap_count", fetch_count, 0);

      // Reset in the middle of a request, then a late ack.
      addr_bus = 8'h55;
      tick();
      tick();
      tick();
      check("midreq_req_before", mem_if.mem_req, 1);
      Rst = 1'b0;
      tick();
      check("midreq_req", mem_if.mem_req, 0);
      check("midreq_valid", ir_valid, 0);
      check("midreq_count", fetch_count, 0);
      check("midreq_err", fetch_err, 0);
      mem_if.mem_ack  = 1'b1;
      mem_if.mem_data = 9'h0F3;
      tick();
      Rst = 1'b1;
      addr_bus = 8'h66;
      tick();
      mem_if.mem_ack = 1'b0;
      check("post_rst_req", mem_if.mem_req, 1);
      check("post_rst_addr", mem_if.mem_addr, 8'h66);
      check("post_rst_valid", ir_valid, 0);
      check("post_rst_ms_m", ms_m, NOP);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
